qmem_arbiter: RTL and testbench

- N-master to 1-slave qmem arbiter. It is the counterpart of the 1-to-N address decoder: it merges several qmem initiators (CPU, DMA, OSD/SPI) onto one qmem slave port, such as SDRAM or boot RAM.
- Arbitration is round-robin with a registered grant, held for the full transfer.
- A watchdog terminates transfers the slave never acknowledges.

---
 rtl/qmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_qmem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/qmem_arbiter.sv
// qmem_arbiter: merges MN qmem initiators onto one qmem slave port.
// Round-robin arbitration with a registered grant that is held for the
// whole transfer, plus an optional watchdog for slaves that never answer.
module qmem_arbiter #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW/8,
  parameter int MN  = 2,
  parameter int TO  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MN-1:0]     qm_cs,
  input  logic [MN-1:0]     qm_we,
  input  logic [MN*QAW-1:0] qm_adr,
  input  logic [MN*QSW-1:0] qm_sel,
  input  logic [MN*QDW-1:0] qm_dat_w,
  output logic [MN*QDW-1:0] qm_dat_r,
  output logic [MN-1:0]     qm_ack,
  output logic [MN-1:0]     qm_err,
  output logic              qs_cs,
  output logic              qs_we,
  output logic [QAW-1:0]    qs_adr,
  output logic [QSW-1:0]    qs_sel,
  output logic [QDW-1:0]    qs_dat_w,
  input  logic [QDW-1:0]    qs_dat_r,
  input  logic              qs_ack,
  input  logic              qs_err,
  output logic [MN-1:0]     gnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int             IW      = (MN > 1) ? $clog2(MN) : 1;
  localparam logic [IW-1:0]  PTR_RST = IW'(MN - 1);
  // Watchdog fires in the cycle where the counter reaches TO-1.
  localparam logic [7:0]     TO_LAST = (TO > 0) ? 8'(TO - 1) : 8'd0;

  state_t          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      wdog_q, wdog_d;

  logic [QAW-1:0]  adr_s [MN];
  logic [QSW-1:0]  sel_s [MN];
  logic [QDW-1:0]  dat_s [MN];

  logic [IW-1:0]   winner;
  logic            any_req;
  logic            in_grant;
  logic            cs_g;
  logic            wdog_hit;

  // Unpack the flat master buses into per-master slices; read data fans out.
  generate
    for (genvar gi = 0; gi < MN; gi++) begin : g_slice
      assign adr_s[gi] = qm_adr[QAW*gi +: QAW];
      assign sel_s[gi] = qm_sel[QSW*gi +: QSW];
      assign dat_s[gi] = qm_dat_w[QDW*gi +: QDW];
      assign qm_dat_r[QDW*gi +: QDW] = qs_dat_r;
    end
  endgenerate

  assign in_grant = (state_q == GRANT);
  assign cs_g     = qm_cs[gidx_q];
  assign wdog_hit = (TO > 0) && in_grant && cs_g && (wdog_q == TO_LAST);

  // Round-robin search: first requester starting just after the last winner.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = ptr_q;
    any_req = 1'b0;
    for (int k = 1; k <= MN; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= MN) idx = idx - MN;
      if (!any_req && qm_cs[idx]) begin
        winner  = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Slave-side mux and per-master response steering from the held grant.
  always_comb begin
    gnt    = '0;
    qm_ack = '0;
    qm_err = '0;
    if (in_grant) begin
      gnt[gidx_q]    = 1'b1;
      qm_ack[gidx_q] = qs_ack & cs_g & ~wdog_hit;
      qm_err[gidx_q] = cs_g & (qs_err | wdog_hit);
    end
    qs_cs    = in_grant & cs_g & ~wdog_hit;
    qs_we    = qm_we[gidx_q];
    qs_adr   = adr_s[gidx_q];
    qs_sel   = sel_s[gidx_q];
    qs_dat_w = dat_s[gidx_q];
  end

  // Next-state logic: grant on any request, release on ack/err/abort/timeout.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gidx_d  = winner;
          ptr_d   = winner;
          wdog_d  = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!cs_g || qs_ack || qs_err || wdog_hit) begin
          state_d = IDLE;
        end else if (wdog_q != 8'hFF) begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers; reset silently drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= PTR_RST;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_qmem_arbiter.sv
// Directed bench for qmem_arbiter: 4 masters, watchdog limit 4.
// Each table row is one clock cycle of stimulus with its expected outputs.
module tb_qmem_arbiter;

  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;
  localparam int MN  = 4;
  localparam int TO  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [MN-1:0]     qm_cs;
  logic [MN-1:0]     qm_we;
  logic [MN*QAW-1:0] qm_adr;
  logic [MN*QSW-1:0] qm_sel;
  logic [MN*QDW-1:0] qm_dat_w;
  logic [MN*QDW-1:0] qm_dat_r;
  logic [MN-1:0]     qm_ack;
  logic [MN-1:0]     qm_err;
  logic              qs_cs;
  logic              qs_we;
  logic [QAW-1:0]    qs_adr;
  logic [QSW-1:0]    qs_sel;
  logic [QDW-1:0]    qs_dat_w;
  logic [QDW-1:0]    qs_dat_r;
  logic              qs_ack;
  logic              qs_err;
  logic [MN-1:0]     gnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qmem_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN), .TO(TO)) u_dut (
    .clk(clk), .rst(rst),
    .qm_cs(qm_cs), .qm_we(qm_we), .qm_adr(qm_adr), .qm_sel(qm_sel),
    .qm_dat_w(qm_dat_w), .qm_dat_r(qm_dat_r), .qm_ack(qm_ack), .qm_err(qm_err),
    .qs_cs(qs_cs), .qs_we(qs_we), .qs_adr(qs_adr), .qs_sel(qs_sel),
    .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
    .gnt(gnt)
  );

  // Fixed per-master transfer attributes.
  logic [QAW-1:0] m_adr [MN] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0020, 32'h0000_0300};
  logic           m_we  [MN] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [QSW-1:0] m_sel [MN] = '{4'hF, 4'hF, 4'b0011, 4'hF};
  logic [QDW-1:0] m_dat [MN] = '{32'h0, 32'h0, 32'h1234_5678, 32'hAAAA_5555};

  typedef struct {
    logic        rst;
    logic [3:0]  cs;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [3:0]  e_gnt;
    logic        e_cs;
    logic [3:0]  e_ack;
    logic [3:0]  e_err;
    int          e_idx;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] cs, input logic a, input logic e,
                     input logic [31:0] d, input logic [3:0] eg, input logic ec,
                     input logic [3:0] ea, input logic [3:0] ee, input int ei);
    vq.push_back('{rst: r, cs: cs, ack: a, err: e, dat: d, e_gnt: eg, e_cs: ec,
                   e_ack: ea, e_err: ee, e_idx: ei});
  endtask

  initial begin
    for (int i = 0; i < MN; i++) begin
      qm_adr[QAW*i +: QAW]   = m_adr[i];
      qm_we[i]               = m_we[i];
      qm_sel[QSW*i +: QSW]   = m_sel[i];
      qm_dat_w[QDW*i +: QDW] = m_dat[i];
    end

    // rst cs  ack err dat            gnt  qs_cs ack  err  idx
    // single master read of m0, data follows ack
    add(0, 4'b0001, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 1, 0, 32'h0,          4'b0001, 1, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 32'hDEAD_BEEF,  4'b0000, 0, 4'b0000, 4'b0000, 0);
    // contention m0/m1, instant slave; last winner was m0 so m1 goes next
    add(0, 4'b0011, 1, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 1, 0, 32'h0,          4'b0010, 1, 4'b0010, 4'b0000, 1);
    add(0, 4'b0011, 1, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 1, 0, 32'h0,          4'b0001, 1, 4'b0001, 4'b0000, 0);
    add(0, 4'b0011, 1, 0, 32'h1111_2222,  4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 1, 0, 32'h0,          4'b0010, 1, 4'b0010, 4'b0000, 1);
    // write routing from m2
    add(0, 4'b0100, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 32'h0,          4'b0100, 1, 4'b0100, 4'b0000, 2);
    // watchdog on m1 while m0 waits; late ack in the timeout cycle is ignored
    add(0, 4'b0010, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 0, 0, 32'h0,          4'b0010, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 0, 0, 32'h0,          4'b0010, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 0, 0, 32'h0,          4'b0010, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 1, 0, 32'h0,          4'b0010, 0, 4'b0000, 4'b0010, 1);
    add(0, 4'b0001, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 0, 0, 32'h0,          4'b0001, 1, 4'b0000, 4'b0000, 0);
    // m0 aborts by dropping cs
    add(0, 4'b0000, 0, 0, 32'h0,          4'b0001, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    // slave error for m1
    add(0, 4'b0010, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 0, 1, 32'h0,          4'b0010, 1, 4'b0000, 4'b0010, 1);
    add(0, 4'b0000, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    // reset mid-grant of m1, then m0 wins first
    add(0, 4'b0010, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0011, 0, 0, 32'h0,          4'b0010, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 1, 0, 32'h5A5A_A5A5,  4'b0001, 1, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 4'b0000, 0);

    // Reset sequence, with a request pending to show it is held off.
    rst = 1'b1; qm_cs = 4'b0001; qs_ack = 1'b1; qs_err = 1'b0; qs_dat_r = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_gnt",   -1, 64'(gnt),    64'h0);
    chk("reset_qs_cs", -1, 64'(qs_cs),  64'h0);
    chk("reset_ack",   -1, 64'(qm_ack), 64'h0);
    chk("reset_err",   -1, 64'(qm_err), 64'h0);
    $display("reset: gnt=%b qs_cs=%b qm_ack=%b qm_err=%b", gnt, qs_cs, qm_ack, qm_err);

    for (int r = 0; r < vq.size(); r++) begin
      @(negedge clk);
      rst = vq[r].rst; qm_cs = vq[r].cs; qs_ack = vq[r].ack; qs_err = vq[r].err;
      qs_dat_r = vq[r].dat;
      #1;
      $display("row %0d: cs=%b ack_in=%b err_in=%b gnt=%b qs_cs=%b qm_ack=%b qm_err=%b",
               r, qm_cs, qs_ack, qs_err, gnt, qs_cs, qm_ack, qm_err);
      chk("gnt",    r, 64'(gnt),    64'(vq[r].e_gnt));
      chk("qs_cs",  r, 64'(qs_cs),  64'(vq[r].e_cs));
      chk("qm_ack", r, 64'(qm_ack), 64'(vq[r].e_ack));
      chk("qm_err", r, 64'(qm_err), 64'(vq[r].e_err));
      for (int s = 0; s < MN; s++)
        chk("qm_dat_r", r, 64'(qm_dat_r[QDW*s +: QDW]), 64'(vq[r].dat));
      if (vq[r].e_cs) begin
        chk("qs_we",    r, 64'(qs_we),    64'(m_we[vq[r].e_idx]));
        chk("qs_adr",   r, 64'(qs_adr),   64'(m_adr[vq[r].e_idx]));
        chk("qs_sel",   r, 64'(qs_sel),   64'(m_sel[vq[r].e_idx]));
        chk("qs_dat_w", r, 64'(qs_dat_w), 64'(m_dat[vq[r].e_idx]));
      end
    end

    // Back-to-back reads by m3 alone with an instant slave: grant every other cycle.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rst = 1'b0; qm_cs = 4'b1000; qs_ack = 1'b1; qs_err = 1'b0; qs_dat_r = 32'h0;
      #1;
      $display("b2b %0d: gnt=%b qm_ack=%b", c, gnt, qm_ack);
      chk("b2b_gnt", c, 64'(gnt),    (c % 2 == 1) ? 64'h8 : 64'h0);
      chk("b2b_ack", c, 64'(qm_ack), (c % 2 == 1) ? 64'h8 : 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
